adder_share_arbiter: RTL and testbench

- Shares one fulladder_32b instance (ports a, b, sum, carry) between two requesters.
- Arbitration is round-robin. Each request runs through a fixed multi-cycle settle window, and the result is returned with a requester tag over a valid/ready response handshake.
- Sits between two datapath clients (e.g. PC-increment unit and ALU issue) and the single shared adder.

---
 rtl/adder_share_arbiter.sv | 132 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares a single 32-bit adder between two requesters
// and returns each tagged result over a valid/ready response handshake.

module fulladder_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum,
   output logic        carry
);
   assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

module adder_share_arbiter #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic                 req1_ready,
   output logic                 rsp_valid,
   output logic                 rsp_id,
   output logic [WIDTH-1:0]     rsp_sum,
   output logic                 rsp_carry,
   input  logic                 rsp_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t               state_q;
   logic [WIDTH-1:0]     op_a_q;
   logic [WIDTH-1:0]     op_b_q;
   logic                 owner_q;
   logic                 last_grant_q;
   logic [3:0]           cnt_q;
   logic                 rsp_valid_q;
   logic                 rsp_id_q;
   logic [WIDTH-1:0]     rsp_sum_q;
   logic                 rsp_carry_q;
   logic                 busy_q;
   logic [CNT_WIDTH-1:0] op_count_q;

   logic [WIDTH-1:0]     adder_sum;
   logic                 adder_carry;
   logic                 any_valid;
   logic                 grant_id;
   logic                 accept;

   fulladder_32b u_adder (
      .a     (op_a_q),
      .b     (op_b_q),
      .sum   (adder_sum),
      .carry (adder_carry)
   );

   // On a tie the requester that did not win last time is served.
   assign any_valid = req0_valid | req1_valid;
   assign grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
   assign accept    = (state_q == IDLE) & any_valid;

   // Readies are forced low while reset is held so nothing looks accepted.
   assign req0_ready = accept & ~grant_id & ~reset;
   assign req1_ready = accept &  grant_id & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_sum_q    <= '0;
         rsp_carry_q  <= 1'b0;
         busy_q       <= 1'b0;
         op_count_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_a_q       <= grant_id ? req1_a : req0_a;
                  op_b_q       <= grant_id ? req1_b : req0_b;
                  owner_q      <= grant_id;
                  last_grant_q <= grant_id;
                  cnt_q        <= CNT_INIT;
                  busy_q       <= 1'b1;
                  state_q      <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  rsp_sum_q   <= adder_sum;
                  rsp_carry_q <= adder_carry;
                  rsp_id_q    <= owner_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + CNT_WIDTH'(1);
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_carry = rsp_carry_q;
   assign busy      = busy_q;
   assign op_count  = op_count_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: one instance with a 1-cycle settle
// window and one with a 3-cycle window.

module tb_adder_share_arbiter;
   typedef struct packed {
      logic        id;
      logic [31:0] sum;
      logic        carry;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        r0v, r1v, rsp_ready;
   logic [31:0] r0a, r0b, r1a, r1b;
   logic        r0rdy, r1rdy, rv, rid, rcar, busy;
   logic [31:0] rsum;
   logic [15:0] cnt;

   logic        t_v, t_zero;
   logic        t_r0rdy, t_r1rdy, t_rv, t_rid, t_rcar, t_busy;
   logic [31:0] t_rsum;
   logic [15:0] t_cnt;

   exp_t        sb[$];
   int          asserts;
   int          errors;
   int          exp_cnt;

   logic [31:0] rr_a0 [2];
   logic [31:0] rr_b0 [2];
   logic [31:0] rr_a1 [2];
   logic [31:0] rr_b1 [2];

   adder_share_arbiter #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0rdy),
      .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1rdy),
      .rsp_valid(rv), .rsp_id(rid), .rsp_sum(rsum), .rsp_carry(rcar),
      .rsp_ready(rsp_ready), .busy(busy), .op_count(cnt)
   );

   adder_share_arbiter #(.WIDTH(32), .SETTLE_CYCLES(3), .CNT_WIDTH(16)) u_dut3 (
      .clk(clk), .reset(reset),
      .req0_valid(t_v), .req0_a(r0a), .req0_b(r0b), .req0_ready(t_r0rdy),
      .req1_valid(t_zero), .req1_a(r1a), .req1_b(r1b), .req1_ready(t_r1rdy),
      .rsp_valid(t_rv), .rsp_id(t_rid), .rsp_sum(t_rsum), .rsp_carry(t_rcar),
      .rsp_ready(rsp_ready), .busy(t_busy), .op_count(t_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mk(input logic id, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      mk = {id, s[31:0], s[32]};
   endfunction

   // Presents one operation on requester n until accepted (bounded), pushing its expectation.
   task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b, output bit got);
      got = 1'b0;
      if (n == 0) begin r0v = 1'b1; r0a = a; r0b = b; end
      else        begin r1v = 1'b1; r1a = a; r1b = b; end
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((n == 0) ? r0rdy : r1rdy) begin
            sb.push_back(mk(n[0], a, b));
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) @(negedge clk);
      if (n == 0) r0v = 1'b0; else r1v = 1'b0;
   endtask

   // Waits (bounded) for a response on the 1-cycle instance with rsp_ready high.
   task automatic collect(output bit got, output exp_t obs);
      got = 1'b0;
      obs = '0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (rv) begin
            obs = {rid, rsum, rcar};
            got = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      r0v = 1'b1; r1v = 1'b0; t_v = 1'b0; t_zero = 1'b0; rsp_ready = 1'b0;
      r0a = '0; r0b = '0; r1a = '0; r1b = '0;
      @(negedge clk);
      #1;
      asserts++;
      if ({r0rdy, r1rdy, rv, rid, rsum, rcar, busy, cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h required 0", {r0rdy, r1rdy, rv, rid, rsum, rcar, busy, cnt});
      end
      asserts++;
      if ({t_r0rdy, t_rv, t_busy, t_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs3 got %h required 0", {t_r0rdy, t_rv, t_busy, t_cnt});
      end
      @(negedge clk);
      r0v = 1'b0;
      reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic;
      exp_t e, o;
      r0v = 1'b1; r0a = 32'h5; r0b = 32'h3; rsp_ready = 1'b1;
      #1;
      asserts++;
      if ({r0rdy, r1rdy} !== 2'b10) begin
         errors++;
         $display("FAIL basic_grant got %b required 10", {r0rdy, r1rdy});
      end
      sb.push_back(mk(1'b0, 32'h5, 32'h3));
      @(negedge clk);
      r0v = 1'b0;
      #1;
      asserts++;
      if ({busy, rv} !== 2'b10) begin
         errors++;
         $display("FAIL basic_cycle1 busy,rv got %b required 10", {busy, rv});
      end
      @(negedge clk);
      #1;
      o = {rid, rsum, rcar};
      e = sb.pop_front();
      asserts++;
      if (rv !== 1'b1 || o !== e) begin
         errors++;
         $display("FAIL basic_rsp rv=%b got %h required %h", rv, o, e);
      end
      @(negedge clk);
      #1;
      exp_cnt = 1;
      asserts++;
      if (cnt !== 16'(exp_cnt) || busy !== 1'b0 || rv !== 1'b0) begin
         errors++;
         $display("FAIL basic_handoff cnt=%0d busy=%b rv=%b required cnt=%0d busy=0 rv=0", cnt, busy, rv, exp_cnt);
      end
      @(negedge clk);
      $display("test_basic op 5+3 done");
   endtask

   task automatic test_carry;
      int          ids [3];
      logic [31:0] as  [3];
      logic [31:0] bs  [3];
      bit          got;
      exp_t        o, e;
      ids = '{0, 1, 1};
      as  = '{32'h80000000, 32'hFFFFFFFF, 32'h12345678};
      bs  = '{32'h80000000, 32'h00000001, 32'h11111111};
      for (int k = 0; k < 3; k++) begin
         issue(ids[k], as[k], bs[k], got);
         asserts++;
         if (!got) begin
            errors++;
            $display("FAIL carry_accept_%0d got timeout required ready", k);
         end
         collect(got, o);
         e = (sb.size() > 0) ? sb.pop_front() : '0;
         exp_cnt++;
         asserts++;
         if (!got || o !== e || cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL carry_rsp_%0d got %h cnt=%0d required %h cnt=%0d", k, o, cnt, e, exp_cnt);
         end
         $display("test_carry op %0d: id=%0d %h+%h -> sum=%h carry=%b", k, ids[k], as[k], bs[k], o.sum, o.carry);
      end
   endtask

   task automatic test_round_robin;
      int   k0, k1, nacc, nrsp;
      logic gid;
      exp_t o, e;
      k0 = 0; k1 = 0; nacc = 0; nrsp = 0;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
         r0v = (k0 < 2); r0a = rr_a0[k0 % 2]; r0b = rr_b0[k0 % 2];
         r1v = (k1 < 2); r1a = rr_a1[k1 % 2]; r1b = rr_b1[k1 % 2];
         #1;
         if (r0rdy && r1rdy) begin
            asserts++;
            errors++;
            $display("FAIL rr_double_grant got both ready required one");
         end else if (r0rdy || r1rdy) begin
            gid = r1rdy;
            asserts++;
            if (gid !== 1'(nacc % 2)) begin
               errors++;
               $display("FAIL rr_grant_%0d got %0d required %0d", nacc, gid, nacc % 2);
            end
            if (gid) begin sb.push_back(mk(1'b1, r1a, r1b)); k1++; end
            else     begin sb.push_back(mk(1'b0, r0a, r0b)); k0++; end
            nacc++;
         end
         if (rv) begin
            o = {rid, rsum, rcar};
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            asserts++;
            if (o !== e) begin
               errors++;
               $display("FAIL rr_rsp_%0d got %h required %h", nrsp, o, e);
            end
            $display("test_round_robin rsp %0d: id=%0d sum=%h", nrsp, o.id, o.sum);
            nrsp++;
            exp_cnt++;
         end
         @(negedge clk);
      end
      r0v = 1'b0; r1v = 1'b0;
      #1;
      asserts++;
      if (nrsp != 4 || cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL rr_complete got %0d rsps cnt=%0d required 4 rsps cnt=%0d", nrsp, cnt, exp_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      bit   seen, got;
      exp_t first, e, o;
      seen = 1'b0;
      rsp_ready = 1'b0;
      r0v = 1'b1; r0a = 32'h100; r0b = 32'h200;
      r1v = 1'b1; r1a = 32'h300; r1b = 32'h400;
      #1;
      asserts++;
      if ({r0rdy, r1rdy} !== 2'b10) begin
         errors++;
         $display("FAIL bp_first_grant got %b required 10", {r0rdy, r1rdy});
      end
      sb.push_back(mk(1'b0, 32'h100, 32'h200));
      @(negedge clk);
      r0a = 32'h500; r0b = 32'h600;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rv) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      first = {rid, rsum, rcar};
      e = sb.pop_front();
      asserts++;
      if (!seen || first !== e) begin
         errors++;
         $display("FAIL bp_rsp seen=%b got %h required %h", seen, first, e);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         asserts++;
         if (rv !== 1'b1 || {rid, rsum, rcar} !== e || r0rdy !== 1'b0 || r1rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall_%0d rv=%b rsp=%h rdy=%b%b busy=%b required rv=1 rsp=%h rdy=00 busy=1",
                     i, rv, {rid, rsum, rcar}, r0rdy, r1rdy, busy, e);
         end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      asserts++;
      if (rv !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_rv got %b required 1", rv);
      end
      exp_cnt++;
      @(negedge clk);
      #1;
      asserts++;
      if ({r0rdy, r1rdy} !== 2'b01 || cnt !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL bp_next_grant rdy=%b%b cnt=%0d required rdy=01 cnt=%0d", r0rdy, r1rdy, cnt, exp_cnt);
      end
      sb.push_back(mk(1'b1, 32'h300, 32'h400));
      @(negedge clk);
      r0v = 1'b0; r1v = 1'b0;
      collect(got, o);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      exp_cnt++;
      asserts++;
      if (!got || o !== e) begin
         errors++;
         $display("FAIL bp_second_rsp got %h required %h", o, e);
      end
      $display("test_backpressure: stalled rsp %h, then id=%0d sum=%h", first, o.id, o.sum);
   endtask

   task automatic test_settle3;
      exp_t e, o;
      rsp_ready = 1'b1;
      t_v = 1'b1; r0a = 32'h7; r0b = 32'h9;
      #1;
      asserts++;
      if (t_r0rdy !== 1'b1) begin
         errors++;
         $display("FAIL s3_grant got %b required 1", t_r0rdy);
      end
      sb.push_back(mk(1'b0, 32'h7, 32'h9));
      @(negedge clk);
      t_v = 1'b0; r0a = 32'h1000; r0b = 32'h2000;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         if (c < 4) begin
            asserts++;
            if (t_rv !== 1'b0) begin
               errors++;
               $display("FAIL s3_early_c%0d got rv=%b required 0", c, t_rv);
            end
         end else begin
            o = {t_rid, t_rsum, t_rcar};
            e = sb.pop_front();
            asserts++;
            if (t_rv !== 1'b1 || o !== e) begin
               errors++;
               $display("FAIL s3_rsp rv=%b got %h required %h", t_rv, o, e);
            end
         end
      end
      @(negedge clk);
      #1;
      asserts++;
      if (t_cnt !== 16'd1) begin
         errors++;
         $display("FAIL s3_count got %0d required 1", t_cnt);
      end
      @(negedge clk);
      $display("test_settle3: 7+9 -> sum=%h after 4 cycles", o.sum);
   endtask

   task automatic test_reset_mid;
      bit   got, seen;
      exp_t e, o;
      rsp_ready = 1'b1;
      issue(0, 32'hA, 32'hB, got);
      reset = 1'b1;
      #1;
      asserts++;
      if (!got || {r0rdy, r1rdy, rv, rid, rsum, rcar, busy, cnt} !== '0) begin
         errors++;
         $display("FAIL rst_settle accepted=%b got %h required 0", got, {r0rdy, r1rdy, rv, rid, rsum, rcar, busy, cnt});
      end
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b0;
      issue(1, 32'hC, 32'hD, got);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rv) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      asserts++;
      if (!seen || {r0rdy, r1rdy, rv, rid, rsum, rcar, busy, cnt} !== '0) begin
         errors++;
         $display("FAIL rst_resp reached=%b got %h required 0", seen, {r0rdy, r1rdy, rv, rid, rsum, rcar, busy, cnt});
      end
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (rv || cnt != 16'd0) seen = 1'b1;
         @(negedge clk);
      end
      asserts++;
      if (seen) begin
         errors++;
         $display("FAIL rst_no_rsp got stale response/count required none");
      end
      r0v = 1'b1; r0a = 32'h21; r0b = 32'h12;
      r1v = 1'b1; r1a = 32'h44; r1b = 32'h55;
      #1;
      asserts++;
      if ({r0rdy, r1rdy} !== 2'b10) begin
         errors++;
         $display("FAIL rst_tie got %b required 10", {r0rdy, r1rdy});
      end
      sb.push_back(mk(1'b0, 32'h21, 32'h12));
      @(negedge clk);
      r0v = 1'b0; r1v = 1'b0;
      collect(got, o);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      asserts++;
      if (!got || o !== e || cnt !== 16'd1) begin
         errors++;
         $display("FAIL rst_post_rsp got %h cnt=%0d required %h cnt=1", o, cnt, e);
      end
      $display("test_reset_mid: post-reset id=%0d sum=%h", o.id, o.sum);
   endtask

   initial begin
      asserts = 0;
      errors  = 0;
      exp_cnt = 0;
      rr_a0 = '{32'h10, 32'h30};
      rr_b0 = '{32'h01, 32'h03};
      rr_a1 = '{32'h20, 32'h40};
      rr_b1 = '{32'h02, 32'h04};
      test_reset();
      test_basic();
      test_carry();
      test_round_robin();
      test_backpressure();
      test_settle3();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
      $finish;
   end
endmodule
